// File: rtl/ht_decoder.sv
// ht_decoder: builds an 8-symbol Huffman tree from serial weights, then decodes serial code bits.
// Define HT_DECODER_PARTIAL_ERR_EN to add code_last/out_err for streams ending mid-codeword.
module ht_decoder #(
  parameter int WW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [WW-1:0] in_weight,
  input  logic          code_valid,
  input  logic          code_bit,
`ifdef HT_DECODER_PARTIAL_ERR_EN
  input  logic          code_last,
  output logic          out_err,
`endif
  output logic          ready,
  output logic          out_valid,
  output logic [2:0]    out_symbol
);
  typedef enum logic [1:0] {IDLE, LOAD, BUILD, READY} state_t;
  state_t state, state_n;
  logic [2:0] cnt;
  logic [WW+2:0] nw [15];
  logic [14:0] live;
  logic [7:0] imem [7];
  logic [7:0] mem [15];
  logic [6:0] code [8];
  logic [2:0] len [8];
  logic [5:0] pc;
  logic [2:0] plen, nl, sym;
  logic [6:0] nc;
  logic [3:0] m0, m1;
  logic f0, f1, start, take, hit;
  assign start = in_valid && (state == IDLE || state == READY);
  assign take  = state == READY && code_valid && !in_valid;
  assign nc    = {pc, code_bit};
  assign nl    = plen + 3'd1;
  assign ready = state == READY;
  // leaf sets per node; scans run in ascending ID order so strict < keeps the lower ID on ties
  always_comb begin
    for (int i = 0; i < 8; i++) mem[i] = 8'(1) << i;
    for (int i = 0; i < 7; i++) mem[i+8] = imem[i];
    m0 = 4'd0;
    m1 = 4'd0;
    f0 = 1'b0;
    f1 = 1'b0;
    for (int i = 0; i < 15; i++)
      if (live[i] && (!f0 || nw[i] < nw[m0])) begin
        m0 = 4'(i);
        f0 = 1'b1;
      end
    for (int i = 0; i < 15; i++)
      if (live[i] && 4'(i) != m0 && (!f1 || nw[i] < nw[m1])) begin
        m1 = 4'(i);
        f1 = 1'b1;
      end
    hit = 1'b0;
    sym = 3'd0;
    for (int j = 0; j < 8; j++)
      if (len[j] == nl && code[j] == nc) begin
        hit = 1'b1;
        sym = 3'(j);
      end
  end
  always_comb begin
    state_n = state;
    if (start) state_n = LOAD;
    else if (state == LOAD && in_valid && cnt == 3'd7) state_n = BUILD;
    else if (state == BUILD && cnt == 3'd6) state_n = READY;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      live <= '0;
      pc <= '0;
      plen <= '0;
      out_valid <= 1'b0;
      out_symbol <= '0;
`ifdef HT_DECODER_PARTIAL_ERR_EN
      out_err <= 1'b0;
`endif
      for (int i = 0; i < 15; i++) nw[i] <= '0;
      for (int i = 0; i < 7; i++) imem[i] <= '0;
      for (int j = 0; j < 8; j++) begin
        code[j] <= '0;
        len[j] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      out_symbol <= '0;
`ifdef HT_DECODER_PARTIAL_ERR_EN
      out_err <= 1'b0;
`endif
      if (start) begin
        cnt <= 3'd1;
        live <= 15'h00ff;
        nw[0] <= {3'b000, in_weight};
        pc <= '0;
        plen <= '0;
        for (int j = 0; j < 8; j++) begin
          code[j] <= '0;
          len[j] <= '0;
        end
      end else if (state == LOAD && in_valid) begin
        nw[{1'b0, cnt}] <= {3'b000, in_weight};
        cnt <= cnt + 3'd1;
      end else if (state == BUILD) begin
        nw[{1'b1, cnt}] <= nw[m0] + nw[m1];
        imem[cnt] <= mem[m0] | mem[m1];
        live <= (live & ~(15'b1 << m0) & ~(15'b1 << m1)) | (15'b1 << {1'b1, cnt});
        cnt <= cnt + 3'd1;
        for (int j = 0; j < 8; j++) begin
          if (mem[m0][j] || mem[m1][j]) len[j] <= len[j] + 3'd1;
          if (mem[m1][j]) code[j] <= code[j] | (7'b1 << len[j]);
        end
      end else if (take) begin
        if (hit) begin
          out_valid <= 1'b1;
          out_symbol <= sym;
          pc <= '0;
          plen <= '0;
`ifdef HT_DECODER_PARTIAL_ERR_EN
        end else if (code_last) begin
          out_err <= 1'b1;
          pc <= '0;
          plen <= '0;
`endif
        end else begin
          pc <= nc[5:0];
          plen <= nl;
        end
      end
    end
endmodule
